fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the register file. Holds the PC, runs a
//  req/ack handshake to instruction memory and latches each word into an instruction
//  register. instr drives the regfile A input (dest [11:9], src0 [8:6], src1 [5:3]).
//  One outstanding request; stall back-pressure and branch redirect from downstream.
// PARAMETERS
//  ADDR_WIDTH   16       PC / imem address width, word-addressed
//  INSTR_WIDTH  16       instruction word width
//  RESET_PC     16'h0000 PC loaded on reset
// PORTS
//  clk            in   1            single clock, rising edge
//  reset          in   1            asynchronous, active-low reset
//  imem_req       out  1            fetch request, held until imem_ack
//  imem_addr      out  ADDR_WIDTH   fetch address, stable while imem_req=1
//  imem_ack       in   1            transfer completes in cycle with imem_req & imem_ack
//  imem_rdata     in   INSTR_WIDTH  instruction word, valid in the ack cycle
//  stall          in   1            downstream cannot accept; hold instr
//  branch_en      in   1            redirect PC to branch_target (1-cycle pulse)
//  branch_target  in   ADDR_WIDTH   redirect address
//  instr          out  INSTR_WIDTH  instruction register -> regfile A
//  instr_valid    out  1            instr holds a live instruction
//  instr_pc       out  ADDR_WIDTH   address instr was fetched from
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, instr_pc=0,
//   imem_req=0, imem_addr=RESET_PC, saved target=0. All outputs registered.
//  States: IDLE, REQ, HOLD, DROP.
//  IDLE: req=0. Next cycle -> REQ (branch_en in IDLE: pc<=branch_target first).
//  REQ: req=1, addr=pc.
//   - ack & !branch_en: instr<=rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1 -> HOLD.
//   - ack & branch_en: discard rdata, pc<=branch_target -> REQ (new addr next cycle).
//   - !ack & branch_en: save target -> DROP (addr must stay stable until ack).
//   - !ack & !branch_en: remain, req and addr unchanged.
//  HOLD: req=0, instr_valid=1.
//   - branch_en (priority over stall): instr_valid<=0, pc<=branch_target -> REQ.
//   - !stall: instr_valid<=0 -> REQ (instruction consumed this cycle).
//   - stall: remain; instr, instr_pc unchanged.
//  DROP: req=1, addr=old pc. branch_en updates saved target (latest wins).
//   ack -> discard rdata, pc<=saved target (or branch_target if branch_en same cycle) -> REQ.
//  Throughput: min 2 cycles/instruction (REQ ack cycle + HOLD cycle); latency ack->instr_valid 1 cycle.
//  PC arithmetic modulo 2^ADDR_WIDTH: 16'hFFFF + 1 wraps to 16'h0000, no flag.
//  Reset asserted mid-handshake: request abandoned, req drops asynchronously; memory
//   side tolerates withdrawn req. Fetch restarts at RESET_PC via IDLE.
//  imem_rdata ignored in all cycles except REQ & ack; ack outside req ignored.
// STRUCTURE
//  Shared package: state encodings (IDLE/REQ/HOLD/DROP), RESET_PC default, field
//   slices INSTR_DEST=[11:9], INSTR_SRC0=[8:6], INSTR_SRC1=[5:3] shared with regfile.
//  One sub-module: pc_counter (load/increment PC register, async active-low reset,
//   wrap-around). FSM, instruction register and handshake logic stay in fetch_unit.
// TESTING
//  1 Reset release, ack every REQ cycle, stall=0 -> addrs 0,1,2,..; instr_valid every
//    2nd cycle, instr=mem[n], instr_pc=n.
//  2 Ack delayed 3 cycles -> req and addr held constant 3 cycles; instr loaded on ack only.
//  3 stall=1 for 4 cycles in HOLD with instr=16'h1234 -> instr/instr_valid stable, no req;
//    stall=0 -> next req at instr_pc+1.
//  4 branch_en to 16'h0040 in REQ without ack -> DROP, old addr held; on ack data
//    discarded, next req addr 16'h0040, no instr_valid for dropped word.
//  5 RESET_PC=16'hFFFF -> fetch FFFF then 0000 (wrap); branch_en+stall in HOLD -> redirect wins.
//  6 reset=0 while req=1 waiting -> req=0, instr_valid=0 immediately; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, reset PC default and the
// instruction field slices that the register file decodes.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2,
    StDrop = 2'd3
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  localparam int unsigned INSTR_FIELD_W  = 3;
  localparam int unsigned INSTR_DEST_LSB = 9;
  localparam int unsigned INSTR_SRC0_LSB = 6;
  localparam int unsigned INSTR_SRC1_LSB = 3;

  function automatic logic [INSTR_FIELD_W-1:0] instr_dest(input logic [15:0] word);
    return word[INSTR_DEST_LSB +: INSTR_FIELD_W];
  endfunction

  function automatic logic [INSTR_FIELD_W-1:0] instr_src0(input logic [15:0] word);
    return word[INSTR_SRC0_LSB +: INSTR_FIELD_W];
  endfunction

  function automatic logic [INSTR_FIELD_W-1:0] instr_src1(input logic [15:0] word);
    return word[INSTR_SRC1_LSB +: INSTR_FIELD_W];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and imem (slave).
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned INSTR_WIDTH = 16
);
  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_pc_counter.sv
// Program counter register: load has priority over increment, increment wraps modulo 2^AddrWidth.
module fetch_unit_pc_counter #(
  parameter int unsigned         AddrWidth = 16,
  parameter logic [AddrWidth-1:0] ResetPc  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [AddrWidth-1:0] load_val_i,
  input  logic                 inc_i,
  output logic [AddrWidth-1:0] pc_o
);

  logic [AddrWidth-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + AddrWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, instruction register with stall
// back-pressure and branch redirect. All outputs come straight from flops.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH  = 16,
  parameter int unsigned          INSTR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_unit_if.master           imem,
  input  logic                   stall,
  input  logic                   branch_en,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic [ADDR_WIDTH-1:0]  instr_pc
);

  fetch_state_e           state_d, state_q;
  logic                   req_d, req_q;
  logic [ADDR_WIDTH-1:0]  addr_d, addr_q;
  logic [INSTR_WIDTH-1:0] instr_d, instr_q;
  logic                   valid_d, valid_q;
  logic [ADDR_WIDTH-1:0]  instr_pc_d, instr_pc_q;
  logic [ADDR_WIDTH-1:0]  tgt_d, tgt_q;

  logic                   pc_load;
  logic                   pc_inc;
  logic [ADDR_WIDTH-1:0]  pc_load_val;
  logic [ADDR_WIDTH-1:0]  pc;

  fetch_unit_pc_counter #(
    .AddrWidth (ADDR_WIDTH),
    .ResetPc   (RESET_PC)
  ) u_pc_counter (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (pc_load),
    .load_val_i (pc_load_val),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    instr_pc_d  = instr_pc_q;
    tgt_d       = tgt_q;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load_val = branch_target;

    case (state_q)
      StIdle: begin
        state_d = StReq;
        req_d   = 1'b1;
        if (branch_en) begin
          pc_load = 1'b1;
          addr_d  = branch_target;
        end else begin
          addr_d  = pc;
        end
      end
      StReq: begin
        if (imem.imem_ack) begin
          if (branch_en) begin
            // Word arrived for a path we just left: drop it and reissue at the target.
            pc_load = 1'b1;
            addr_d  = branch_target;
          end else begin
            instr_d    = imem.imem_rdata;
            instr_pc_d = pc;
            valid_d    = 1'b1;
            pc_inc     = 1'b1;
            req_d      = 1'b0;
            state_d    = StHold;
          end
        end else if (branch_en) begin
          // Address must stay stable until ack, so park the target and wait.
          tgt_d   = branch_target;
          state_d = StDrop;
        end
      end
      StHold: begin
        if (branch_en) begin
          valid_d = 1'b0;
          pc_load = 1'b1;
          addr_d  = branch_target;
          req_d   = 1'b1;
          state_d = StReq;
        end else if (!stall) begin
          valid_d = 1'b0;
          addr_d  = pc;
          req_d   = 1'b1;
          state_d = StReq;
        end
      end
      StDrop: begin
        if (imem.imem_ack) begin
          pc_load     = 1'b1;
          pc_load_val = branch_en ? branch_target : tgt_q;
          addr_d      = pc_load_val;
          req_d       = 1'b1;
          state_d     = StReq;
        end else if (branch_en) begin
          tgt_d = branch_target;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      instr_pc_q <= '0;
      tgt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      instr_pc_q <= instr_pc_d;
      tgt_q      <= tgt_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign instr_pc       = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of accepted fetches checked when instr_valid rises.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset0, reset1;
  logic        stall0, branch0, stall1, branch1;
  logic [15:0] tgt0, tgt1;
  logic [15:0] instr0, instr1, instr_pc0, instr_pc1;
  logic        valid0, valid1;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic valid_prev = 1'b0;

  fetch_unit_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(16)) i0 ();
  fetch_unit_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(16)) i1 ();

  fetch_unit #(.ADDR_WIDTH(16), .INSTR_WIDTH(16), .RESET_PC(16'h0000)) u_dut0 (
    .clk           (clk),
    .reset         (reset0),
    .imem          (i0),
    .stall         (stall0),
    .branch_en     (branch0),
    .branch_target (tgt0),
    .instr         (instr0),
    .instr_valid   (valid0),
    .instr_pc      (instr_pc0)
  );

  fetch_unit #(.ADDR_WIDTH(16), .INSTR_WIDTH(16), .RESET_PC(16'hFFFF)) u_dut1 (
    .clk           (clk),
    .reset         (reset1),
    .imem          (i1),
    .stall         (stall1),
    .branch_en     (branch1),
    .branch_target (tgt1),
    .instr         (instr1),
    .instr_valid   (valid1),
    .instr_pc      (instr_pc1)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return (a * 16'h1357) ^ 16'h0A5A;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and retire a scoreboard entry on each new instruction.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (valid0 === 1'b1 && !valid_prev) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed instr %h pc %h expected none", instr0, instr_pc0);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check16("sb_instr", instr0, e.data);
        check16("sb_pc", instr_pc0, e.pc);
        check16("sb_fields",
                16'({instr_dest(instr0), instr_src0(instr0), instr_src1(instr0)}),
                16'({instr_dest(e.data), instr_src0(e.data), instr_src1(e.data)}));
      end
    end
    valid_prev = valid0;
  endtask

  // One immediate-ack fetch on dut0 starting from a REQ cycle, ending at the next REQ cycle.
  task automatic fetch_step(input logic [15:0] addr, input logic [15:0] data);
    check1("req_high", i0.imem_req, 1'b1);
    check16("req_addr", i0.imem_addr, addr);
    check1("valid_low_in_req", valid0, 1'b0);
    i0.imem_ack   = 1'b1;
    i0.imem_rdata = data;
    sb.push_back('{pc: addr, data: data});
    tick();
    i0.imem_ack   = 1'b0;
    i0.imem_rdata = 16'hBAD0;
    check1("req_low_in_hold", i0.imem_req, 1'b0);
    check1("valid_in_hold", valid0, 1'b1);
    tick();
  endtask

  initial begin
    reset0 = 1'b0;  reset1 = 1'b0;
    stall0 = 1'b0;  branch0 = 1'b0; tgt0 = '0;
    stall1 = 1'b0;  branch1 = 1'b0; tgt1 = '0;
    i0.imem_ack = 1'b0; i0.imem_rdata = '0;
    i1.imem_ack = 1'b0; i1.imem_rdata = '0;

    // Reset state
    tick();
    check1("rst_req", i0.imem_req, 1'b0);
    check16("rst_addr", i0.imem_addr, 16'h0000);
    check1("rst_valid", valid0, 1'b0);
    check16("rst_instr", instr0, 16'h0000);
    check16("rst_instr_pc", instr_pc0, 16'h0000);
    check16("rst_addr_wrapdut", i1.imem_addr, 16'hFFFF);
    reset0 = 1'b1;
    tick();

    // 1: back-to-back fetches
    for (int n = 0; n < 5; n++) fetch_step(16'(n), mem(16'(n)));

    // 2: ack delayed three cycles, rdata noise ignored
    i0.imem_rdata = 16'hEEEE;
    for (int i = 0; i < 3; i++) begin
      check1("wait_req", i0.imem_req, 1'b1);
      check16("wait_addr", i0.imem_addr, 16'h0005);
      check1("wait_valid", valid0, 1'b0);
      tick();
    end
    fetch_step(16'h0005, mem(16'h0005));

    // 3: stall in HOLD
    check16("t3_addr", i0.imem_addr, 16'h0006);
    i0.imem_ack = 1'b1; i0.imem_rdata = 16'h1234; stall0 = 1'b1;
    sb.push_back('{pc: 16'h0006, data: 16'h1234});
    tick();
    i0.imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check1("stall_valid", valid0, 1'b1);
      check16("stall_instr", instr0, 16'h1234);
      check1("stall_req", i0.imem_req, 1'b0);
      if (i == 3) stall0 = 1'b0;
      tick();
    end
    check1("post_stall_req", i0.imem_req, 1'b1);
    check16("post_stall_addr", i0.imem_addr, 16'h0007);

    // 4: branch while waiting -> DROP, old address held, word discarded
    branch0 = 1'b1; tgt0 = 16'h0040;
    tick();
    branch0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check1("drop_req", i0.imem_req, 1'b1);
      check16("drop_addr", i0.imem_addr, 16'h0007);
      if (i == 0) tick();
    end
    i0.imem_ack = 1'b1; i0.imem_rdata = 16'hDEAD;
    tick();
    i0.imem_ack = 1'b0;
    check16("redirect_addr", i0.imem_addr, 16'h0040);
    check1("redirect_valid", valid0, 1'b0);
    fetch_step(16'h0040, mem(16'h0040));

    // ack and branch together in REQ
    check16("ackbr_addr", i0.imem_addr, 16'h0041);
    i0.imem_ack = 1'b1; i0.imem_rdata = 16'hBEEF; branch0 = 1'b1; tgt0 = 16'h0080;
    tick();
    i0.imem_ack = 1'b0; branch0 = 1'b0;
    check1("ackbr_req", i0.imem_req, 1'b1);
    check16("ackbr_new_addr", i0.imem_addr, 16'h0080);
    check1("ackbr_valid", valid0, 1'b0);

    // latest branch in DROP wins
    branch0 = 1'b1; tgt0 = 16'h0090;
    tick();
    tgt0 = 16'h00A0;
    tick();
    branch0 = 1'b0;
    check16("drop2_addr", i0.imem_addr, 16'h0080);
    i0.imem_ack = 1'b1; i0.imem_rdata = 16'hCAFE;
    tick();
    i0.imem_ack = 1'b0;
    check16("drop2_target", i0.imem_addr, 16'h00A0);
    fetch_step(16'h00A0, mem(16'h00A0));

    // 5: RESET_PC = FFFF wraps to 0000; branch beats stall in HOLD
    reset1 = 1'b1;
    tick();
    check1("w_req", i1.imem_req, 1'b1);
    check16("w_addr0", i1.imem_addr, 16'hFFFF);
    i1.imem_ack = 1'b1; i1.imem_rdata = 16'h1111;
    tick();
    i1.imem_ack = 1'b0;
    check1("w_valid0", valid1, 1'b1);
    check16("w_instr0", instr1, 16'h1111);
    check16("w_pc0", instr_pc1, 16'hFFFF);
    tick();
    check16("w_addr1", i1.imem_addr, 16'h0000);
    i1.imem_ack = 1'b1; i1.imem_rdata = 16'h0E38;
    tick();
    i1.imem_ack = 1'b0;
    check16("w_pc1", instr_pc1, 16'h0000);
    stall1 = 1'b1; branch1 = 1'b1; tgt1 = 16'h0100;
    tick();
    branch1 = 1'b0; stall1 = 1'b0;
    check1("w_br_req", i1.imem_req, 1'b1);
    check16("w_br_addr", i1.imem_addr, 16'h0100);
    check1("w_br_valid", valid1, 1'b0);

    // 6: async reset while a request is outstanding
    check1("pre_rst_req", i0.imem_req, 1'b1);
    check16("pre_rst_addr", i0.imem_addr, 16'h00A1);
    #2 reset0 = 1'b0;
    #1;
    check1("async_rst_req", i0.imem_req, 1'b0);
    check1("async_rst_valid", valid0, 1'b0);
    check16("async_rst_addr", i0.imem_addr, 16'h0000);
    tick();
    reset0 = 1'b1;
    tick();
    fetch_step(16'h0000, mem(16'h0000));

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
